// File: rtl/frame_reception.sv
// Receive side of the 8-bit framed link: locks onto preamble/SFD, deserialises
// dest/src/type/data, checks the CRC-32 residue and filters on destination address.
module frame_reception #(
    parameter logic [47:0] MAC_ADDR = 48'h123456789ABC,
    parameter bit          PROMISC  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_in,
    output logic [47:0] dest_out,
    output logic [47:0] src_out,
    output logic [15:0] type_out,
    output logic [31:0] data_out,
    output logic        rx_busy,
    output logic        rx_done,
    output logic        rx_err
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [2:0]  PRE_MAX     = 3'd7;
    localparam logic [4:0]  LAST_HDR    = 5'd13;
    localparam logic [4:0]  LAST_PAY    = 5'd17;
    localparam logic [4:0]  LAST_FCS    = 5'd21;

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, DROP} state_t;

    state_t      state, state_d;
    logic [2:0]  pre_cnt;
    logic [4:0]  byte_cnt;
    logic [31:0] crc, crc_step;
    logic [47:0] dest_sh, src_sh;
    logic [15:0] type_sh;
    logic [31:0] data_sh;
    logic        sfd_hit, body_byte, pre_inc, frame_end, trunc;
    logic        crc_ok, addr_ok, accept, reject;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        sfd_hit   = 1'b0;
        body_byte = 1'b0;
        pre_inc   = 1'b0;
        frame_end = 1'b0;
        trunc     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv) state_d = (rx_in == PRE_BYTE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (rx_in == PRE_BYTE) begin
                    if (pre_cnt == PRE_MAX) state_d = DROP;
                    else                    pre_inc = 1'b1;
                end else if (rx_in == SFD_BYTE) begin
                    state_d = HEADER;
                    sfd_hit = 1'b1;
                end else begin
                    state_d = DROP;
                end
            end
            HEADER, PAYLOAD, FCS: begin
                if (!rx_dv) begin
                    trunc   = 1'b1;
                    state_d = IDLE;
                end else begin
                    body_byte = 1'b1;
                    if (state == HEADER && byte_cnt == LAST_HDR) state_d = PAYLOAD;
                    if (state == PAYLOAD && byte_cnt == LAST_PAY) state_d = FCS;
                    if (state == FCS && byte_cnt == LAST_FCS) begin
                        frame_end = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                if (!rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The residue test folds the received FCS into the running CRC, so the
    // last FCS byte must be included via the combinational step.
    assign crc_step = crc_byte(crc, rx_in);
    assign crc_ok   = (crc_step == CRC_RESIDUE);
    assign addr_ok  = PROMISC || (dest_sh == MAC_ADDR) || (dest_sh == 48'hFFFFFFFFFFFF);
    assign accept   = frame_end && crc_ok && addr_ok;
    assign reject   = (frame_end && !crc_ok) || trunc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            byte_cnt <= '0;
            crc      <= CRC_INIT;
            dest_sh  <= '0;
            src_sh   <= '0;
            type_sh  <= '0;
            data_sh  <= '0;
            dest_out <= '0;
            src_out  <= '0;
            type_out <= '0;
            data_out <= '0;
            rx_busy  <= 1'b0;
            rx_done  <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            if (state != PREAMBLE) pre_cnt <= 3'd1;
            else if (pre_inc)      pre_cnt <= pre_cnt + 3'd1;

            if (sfd_hit) begin
                byte_cnt <= '0;
                crc      <= CRC_INIT;
            end else if (body_byte) begin
                byte_cnt <= byte_cnt + 5'd1;
                crc      <= crc_step;
                if (byte_cnt < 5'd6)       dest_sh <= {dest_sh[39:0], rx_in};
                else if (byte_cnt < 5'd12) src_sh  <= {src_sh[39:0], rx_in};
                else if (byte_cnt < 5'd14) type_sh <= {type_sh[7:0], rx_in};
                else if (byte_cnt < 5'd18) data_sh <= {data_sh[23:0], rx_in};
            end

            if (sfd_hit)                 rx_busy <= 1'b1;
            else if (frame_end || trunc) rx_busy <= 1'b0;

            rx_done <= accept;
            rx_err  <= reject;
            if (accept) begin
                dest_out <= dest_sh;
                src_out  <= src_sh;
                type_out <= type_sh;
                data_out <= data_sh;
            end
        end
    end
endmodule

// File: tb/tb_frame_reception.sv
// Bench for frame_reception: vector table, randomized frames against a
// frame-level model, back-to-back and mid-frame reset sequences.
module tb_frame_reception;
    localparam logic [47:0] MAC = 48'h123456789ABC;
    localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;

    logic        clk, rst_n, rx_dv;
    logic [7:0]  rx_in;
    logic [47:0] dest_o [2];
    logic [47:0] src_o  [2];
    logic [15:0] type_o [2];
    logic [31:0] data_o [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        err_o  [2];

    frame_reception #(.MAC_ADDR(MAC), .PROMISC(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_in(rx_in),
        .dest_out(dest_o[0]), .src_out(src_o[0]), .type_out(type_o[0]), .data_out(data_o[0]),
        .rx_busy(busy_o[0]), .rx_done(done_o[0]), .rx_err(err_o[0]));

    frame_reception #(.MAC_ADDR(MAC), .PROMISC(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_in(rx_in),
        .dest_out(dest_o[1]), .src_out(src_o[1]), .type_out(type_o[1]), .data_out(data_o[1]),
        .rx_busy(busy_o[1]), .rx_done(done_o[1]), .rx_err(err_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pre;
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] ty;
        logic [31:0] data;
        bit          corrupt;
        bit          bad_pre;
        int          cut;
        int          k0;
        int          k1;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   frm[$];
    bit           frm_dv[$];
    logic [143:0] exp_f [2];
    int           dn_cnt[2], er_cnt[2], dn_at[2], er_at[2], ovl[2];
    logic [175:0] cap0[$];
    bit           busy_h[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [143:0] fields(input int i);
        return {dest_o[i], src_o[i], type_o[i], data_o[i]};
    endfunction

    // Ethernet FCS over n bytes of frm starting at 'from'
    function automatic logic [31:0] fcs32(input int from, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            c = c ^ {24'h0, frm[from + k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push(input logic [7:0] b, input bit dv);
        frm.push_back(b);
        frm_dv.push_back(dv);
    endtask

    task automatic clear();
        frm.delete();
        frm_dv.delete();
    endtask

    task automatic append(input int pre, input logic [47:0] d, input logic [47:0] s,
                          input logic [15:0] ty, input logic [31:0] da, input bit corrupt,
                          input bit bad_pre, input int cut, input int extra);
        int base = frm.size();
        logic [31:0] f;
        for (int k = 0; k < pre; k++) push(8'h55, 1'b1);
        push(8'hD5, 1'b1);
        for (int k = 0; k < 6; k++) push(d[47-8*k -: 8], 1'b1);
        for (int k = 0; k < 6; k++) push(s[47-8*k -: 8], 1'b1);
        for (int k = 0; k < 2; k++) push(ty[15-8*k -: 8], 1'b1);
        for (int k = 0; k < 4; k++) push(da[31-8*k -: 8], 1'b1);
        f = fcs32(base + pre + 1, 18);
        for (int k = 0; k < 4; k++) push(f[8*k +: 8], 1'b1);
        if (corrupt) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        if (bad_pre) frm[base+1] = 8'h12;
        if (cut >= 0) begin
            while (frm.size() > base + pre + 1 + cut) begin
                void'(frm.pop_back());
                void'(frm_dv.pop_back());
            end
        end else begin
            for (int k = 0; k < extra; k++) push(8'($urandom), 1'b1);
        end
    endtask

    // Frame-level expectation for a single contiguous frame in frm:
    // kind 0 = nothing, 1 = done, 2 = error; idx = sample index of the pulse.
    task automatic model(input bit promisc, output int kind, output int idx,
                         output int sfd, output logic [143:0] f);
        int n = 0;
        int L = frm.size();
        logic [31:0] rx_fcs;
        kind = 0; idx = -1; sfd = -1; f = '0;
        while (n < L && frm[n] == 8'h55) n++;
        if (n == 0 || n > 7 || n >= L || frm[n] != 8'hD5) return;
        sfd = n;
        if (L < n + 23) begin
            kind = 2; idx = L + 1;
            return;
        end
        for (int k = 0; k < 18; k++) f = {f[135:0], frm[n+1+k]};
        rx_fcs = {frm[n+22], frm[n+21], frm[n+20], frm[n+19]};
        idx = n + 23;
        if (rx_fcs != fcs32(n + 1, 18)) kind = 2;
        else if (promisc || f[143:96] == MAC || f[143:96] == BC) kind = 1;
    endtask

    // Sample at each negedge (reflecting the previous rising edge), then drive byte t.
    task automatic drive();
        int L = frm.size();
        for (int i = 0; i < 2; i++) begin
            dn_cnt[i] = 0; er_cnt[i] = 0; dn_at[i] = -1; er_at[i] = -1; ovl[i] = 0;
        end
        cap0.delete();
        busy_h.delete();
        for (int t = 0; t <= L + 3; t++) begin
            @(negedge clk);
            busy_h.push_back(busy_o[0]);
            for (int i = 0; i < 2; i++) begin
                if (done_o[i]) begin dn_cnt[i]++; if (dn_at[i] < 0) dn_at[i] = t; end
                if (err_o[i])  begin er_cnt[i]++; if (er_at[i] < 0) er_at[i] = t; end
                if (done_o[i] && err_o[i]) ovl[i]++;
            end
            if (done_o[0]) cap0.push_back({32'(t), fields(0)});
            if (t < L) begin
                rx_dv = frm_dv[t];
                rx_in = frm[t];
            end else begin
                rx_dv = 1'b0;
                rx_in = 8'($urandom);
            end
        end
    endtask

    task automatic check_frame(input string nm, input int k0, input int k1,
                               input logic [143:0] f, input int idx, input int sfd);
        int k;
        for (int i = 0; i < 2; i++) begin
            k = (i == 0) ? k0 : k1;
            chk($sformatf("%s u%0d done_cnt", nm, i), dn_cnt[i], (k == 1) ? 1 : 0);
            chk($sformatf("%s u%0d err_cnt", nm, i), er_cnt[i], (k == 2) ? 1 : 0);
            chk($sformatf("%s u%0d overlap", nm, i), ovl[i], 0);
            if (k == 1) begin
                chk($sformatf("%s u%0d done_at", nm, i), dn_at[i], idx);
                exp_f[i] = f;
            end
            if (k == 2) chk($sformatf("%s u%0d err_at", nm, i), er_at[i], idx);
            chk($sformatf("%s u%0d fields", nm, i), fields(i), exp_f[i]);
            chk($sformatf("%s u%0d busy_end", nm, i), busy_o[i], 1'b0);
        end
        if (sfd >= 0 && sfd + 1 < busy_h.size())
            chk($sformatf("%s busy_after_sfd", nm), busy_h[sfd+1], 1'b1);
    endtask

    task automatic check_reset(input string nm);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s u%0d", nm, i),
                {fields(i), busy_o[i], done_o[i], err_o[i]}, '0);
    endtask

    initial begin
        vec_t         tbl[11];
        int           k0, k1, idx, sfd, kd;
        logic [143:0] f;
        logic [47:0]  d;
        logic [143:0] fa, fb;
        int           pre, cut, sel;
        bit           cor, bp;

        tbl[0]  = '{7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 0, 0, -1, 1, 1};
        tbl[1]  = '{7, MAC, 48'hABCDEF123456, 16'h0800, 32'hCAFEF00D, 1, 0, -1, 2, 2};
        tbl[2]  = '{7, MAC, 48'h010203040506, 16'h86DD, 32'h01234567, 0, 0, 10, 2, 2};
        tbl[3]  = '{7, 48'h0000000000AA, 48'h111111111111, 16'h0806, 32'h89ABCDEF, 0, 0, -1, 0, 1};
        tbl[4]  = '{7, BC, 48'h222222222222, 16'h0800, 32'h13579BDF, 0, 0, -1, 1, 1};
        tbl[5]  = '{7, MAC, 48'h333333333333, 16'h0800, 32'h2468ACE0, 0, 1, -1, 0, 0};
        tbl[6]  = '{1, MAC, 48'h444444444444, 16'h0801, 32'hA5A5A5A5, 0, 0, -1, 1, 1};
        tbl[7]  = '{8, MAC, 48'h555555555555, 16'h0802, 32'h5A5A5A5A, 0, 0, -1, 0, 0};
        tbl[8]  = '{0, MAC, 48'h666666666666, 16'h0803, 32'h0F0F0F0F, 0, 0, -1, 0, 0};
        tbl[9]  = '{3, MAC, 48'h777777777777, 16'h0804, 32'hF0F0F0F0, 0, 0, 21, 2, 2};
        tbl[10] = '{5, 48'h0000000000AA, 48'h888888888888, 16'h0805, 32'h11111111, 1, 0, -1, 2, 2};

        rst_n = 1'b1;
        rx_dv = 1'b0;
        rx_in = 8'h00;
        exp_f[0] = '0;
        exp_f[1] = '0;
        #2 rst_n = 1'b0;
        #1 check_reset("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            clear();
            append(tbl[v].pre, tbl[v].dest, tbl[v].src, tbl[v].ty, tbl[v].data,
                   tbl[v].corrupt, tbl[v].bad_pre, tbl[v].cut, 0);
            model(1'b0, kd, idx, sfd, f);
            drive();
            check_frame($sformatf("vec%0d", v), tbl[v].k0, tbl[v].k1,
                        {tbl[v].dest, tbl[v].src, tbl[v].ty, tbl[v].data}, idx, sfd);
        end

        // back-to-back frames separated by one idle cycle
        fa = {MAC, 48'hA1A2A3A4A5A6, 16'h0800, 32'h11223344};
        fb = {BC,  48'hB1B2B3B4B5B6, 16'h0806, 32'h55667788};
        clear();
        append(7, fa[143:96], fa[95:48], fa[47:32], fa[31:0], 0, 0, -1, 0);
        push(8'h00, 1'b0);
        append(7, fb[143:96], fb[95:48], fb[47:32], fb[31:0], 0, 0, -1, 0);
        drive();
        chk("b2b u0 done_cnt", dn_cnt[0], 2);
        chk("b2b u1 done_cnt", dn_cnt[1], 2);
        chk("b2b u0 err_cnt", er_cnt[0], 0);
        chk("b2b cap_cnt", cap0.size(), 2);
        if (cap0.size() >= 2) begin
            chk("b2b first", cap0[0], {32'd30, fa});
            chk("b2b second", cap0[1], {32'd61, fb});
        end
        exp_f[0] = fb;
        exp_f[1] = fb;
        chk("b2b u1 fields", fields(1), fb);

        // randomized frames against the frame-level model
        for (int r = 0; r < 40; r++) begin
            pre = $urandom_range(0, 9);
            if (pre == 9) pre = 7;
            sel = $urandom_range(0, 3);
            d   = (sel == 0) ? MAC : (sel == 1) ? BC : (sel == 2) ? 48'hAA : {16'($urandom), 32'($urandom)};
            cor = ($urandom_range(0, 4) == 0);
            cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 21)) : -1;
            bp  = (pre >= 2) && ($urandom_range(0, 9) == 0);
            clear();
            append(pre, d, {16'($urandom), 32'($urandom)}, 16'($urandom), 32'($urandom),
                   cor, bp, cut, $urandom_range(0, 2));
            model(1'b0, k0, idx, sfd, f);
            model(1'b1, k1, idx, sfd, f);
            drive();
            check_frame($sformatf("rnd%0d", r), k0, k1, f, idx, sfd);
        end

        // reset in the middle of the payload
        clear();
        append(7, MAC, 48'hC1C2C3C4C5C6, 16'h0800, 32'h99999999, 0, 0, -1, 0);
        for (int t = 0; t < 7 + 17; t++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rx_in = frm[t];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset("midframe_reset");
        rx_dv = 1'b0;
        exp_f[0] = '0;
        exp_f[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clear();
        append(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 0, 0, -1, 0);
        model(1'b0, kd, idx, sfd, f);
        drive();
        check_frame("after_reset", 1, 1, f, idx, sfd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_reception.md
# frame_reception

Receive-side counterpart of `frame_transmission`. It sits directly downstream of the transmitter's byte stream, or of the PHY receive interface in the same 8-bit format. It consumes an 8-bit byte stream qualified by a data-valid strobe and locks onto the preamble/SFD. It then deserialises destination address, source address, EtherType and a 32-bit payload word, checks the CRC-32 FCS, applies destination-address filtering, and presents the parsed fields with a single-cycle done or error strobe.

## Interface
- `MAC_ADDR`, default 48'h123456789ABC: station address accepted by the filter.
- `PROMISC`, default 0: 1 accepts any destination address.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_dv`  in  1  byte-valid strobe, same role as transmitter `tx_en`.
- `rx_in`  in  8  received byte, sampled when `rx_dv`=1.
- `dest_out`  out  48  parsed destination address.
- `src_out`  out  48  parsed source address.
- `type_out`  out  16  parsed EtherType.
- `data_out`  out  32  parsed payload word.
- `rx_busy`  out  1  high from accepted SFD until the frame ends.
- `rx_done`  out  1  1-cycle pulse: good frame accepted, outputs updated.
- `rx_err`  out  1  1-cycle pulse: CRC mismatch or truncated frame.

## Operation
- Frame format, in byte order:
  - preamble: 1–7 × 0x55
  - SFD: 0xD5
  - dest: 6 bytes, [47:40] first
  - src: 6 bytes, [47:40] first
  - type: 2 bytes, [15:8] first
  - data: 4 bytes, [31:24] first
  - FCS: 4 bytes, LSB byte first
- The frame body is 22 bytes after the SFD.
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, DROP.
- IDLE:
  - `rx_dv`=1 and `rx_in`=0x55 → PREAMBLE.
  - Any other byte → DROP.
- PREAMBLE:
  - 0x55 → stay.
  - 0xD5 → HEADER; byte counter cleared, CRC register loaded with 32'hFFFFFFFF, `rx_busy`=1.
  - Any other byte, or more than 7 × 0x55 → DROP, no error.
  - `rx_dv` falling → IDLE.
- HEADER: 14 bytes shifted into shadow registers for dest/src/type → PAYLOAD.
- PAYLOAD: 4 bytes into the data shadow register → FCS.
- FCS: after the 4th FCS byte, evaluate the frame, then go to DROP, or to IDLE if `rx_dv` is already low.
- DROP: ignores all bytes, returns to IDLE on the first cycle `rx_dv`=0. Bytes beyond the 22nd are ignored this way.
- CRC-32:
  - Reflected polynomial 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF.
  - Computed over all 22 bytes, dest through FCS inclusive.
  - Frame is good iff the final register equals the residue 32'hDEBB20E3.
- Address filter: pass iff dest == `MAC_ADDR`, dest == 48'hFFFFFFFFFFFF, or `PROMISC`=1.
- Evaluation at frame end:
  - Good CRC and filter pass → shadow registers copied to outputs, `rx_done` pulse.
  - Bad CRC → `rx_err` pulse, outputs unchanged.
  - Good CRC but filter fails → silent discard: no pulse, outputs unchanged.
- Truncation: `rx_dv` low while in HEADER, PAYLOAD or FCS → `rx_err` pulse, outputs unchanged, → IDLE.
- Shadow registers isolate the outputs, so they change only on `rx_done`.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - CRC register 32'hFFFFFFFF
  - counter 0
- One byte is consumed per cycle with `rx_dv`=1.
- `rx_dv` must stay high from the first preamble byte to the last FCS byte; gaps count as truncation.
- `rx_done`/`rx_err` assert in the cycle after the 4th FCS byte is sampled, or after `rx_dv` is first seen low. The outputs update on that same edge.
- Done/error pulses are exactly 1 cycle, mutually exclusive, and never both asserted.
- `rx_busy` deasserts on the same edge that `rx_done`/`rx_err` asserts, and also on silent discard.
- SFD-to-`rx_done` latency is 23 cycles: 22 body bytes plus 1.
- Back-to-back frames:
  - A new preamble can start the cycle after `rx_dv` goes low.
  - A minimum of 1 idle cycle between frames is required.
- Reset mid-frame: everything returns to reset values immediately and asynchronously. No pulse is generated and the partial frame is lost.

## Test plan
- Good frame: 7×0x55, 0xD5, dest 123456789ABC, src ABCDEF123456, type 0800, data DEADBEEF, correct FCS from the bench CRC model → `rx_done` 1 cycle at SFD+23 with all four fields matching; `rx_err` stays 0.
- Corrupt FCS: same frame with the last FCS byte XOR 0x01 → `rx_err` pulse; `rx_done` 0; outputs retain previous values.
- Truncation: drop `rx_dv` after the 10th body byte → `rx_err` next cycle; `rx_busy` 0; state IDLE.
- Filter:
  - dest 0x0000000000AA, good FCS, `PROMISC`=0 → no pulse, outputs unchanged.
  - Broadcast dest FFFFFFFFFFFF → `rx_done`.
  - `PROMISC`=1 with dest 0x0000000000AA → `rx_done`.
- Preamble robustness:
  - Preamble 0x55, 0x12, … → DROP, no pulse.
  - Preamble of 1×0x55 then SFD → accepted.
  - Two good frames with 1 idle cycle between → two `rx_done` pulses with the correct fields each.
- Reset mid-frame: assert `rst_n`=0 during PAYLOAD → all outputs 0 immediately; the next good frame is received normally.
